// File: rtl/sram_bus_arbiter.sv
// Serialises the core's inst/data SRAM requests onto one memory port, one transaction outstanding.
// Latency: capture in N, mem_req from N+1, read data registered and stallreq low one cycle after data_ok.
// Backpressure: stallreq freezes the pipeline whenever not IDLE; mem_req is held until mem_addr_ok.
module sram_bus_arbiter #(
   parameter int DATA_FIRST = 1,
   parameter int AW         = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inst_sram_en,
   input  logic [3:0]    inst_sram_wen,
   input  logic [AW-1:0] inst_sram_addr,
   input  logic [AW-1:0] inst_sram_wdata,
   output logic [AW-1:0] inst_sram_rdata,
   input  logic          data_sram_en,
   input  logic [3:0]    data_sram_wen,
   input  logic [AW-1:0] data_sram_addr,
   input  logic [AW-1:0] data_sram_wdata,
   output logic [AW-1:0] data_sram_rdata,
   output logic          stallreq,
   output logic          mem_req,
   output logic          mem_wr,
   output logic [3:0]    mem_wstrb,
   output logic [AW-1:0] mem_addr,
   output logic [AW-1:0] mem_wdata,
   input  logic          mem_addr_ok,
   input  logic          mem_data_ok,
   input  logic [AW-1:0] mem_rdata
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      D_REQ  = 3'd1,
      D_WAIT = 3'd2,
      I_REQ  = 3'd3,
      I_WAIT = 3'd4
   } state_t;

   state_t state;
   state_t state_next;

   // Pending request slots, filled only while IDLE so they stay stable for the whole freeze.
   logic          i_pend;
   logic [3:0]    i_wen;
   logic [AW-1:0] i_addr;
   logic [AW-1:0] i_wdata;
   logic          d_pend;
   logic [3:0]    d_wen;
   logic [AW-1:0] d_addr;
   logic [AW-1:0] d_wdata;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: pick the first-priority captured slot, then chain to the other slot if still pending.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (data_sram_en && ((DATA_FIRST != 0) || !inst_sram_en)) begin
               state_next = D_REQ;
            end else if (inst_sram_en) begin
               state_next = I_REQ;
            end
         end
         D_REQ: begin
            if (mem_addr_ok) begin
               state_next = D_WAIT;
            end
         end
         D_WAIT: begin
            if (mem_data_ok) begin
               state_next = i_pend ? I_REQ : IDLE;
            end
         end
         I_REQ: begin
            if (mem_addr_ok) begin
               state_next = I_WAIT;
            end
         end
         I_WAIT: begin
            if (mem_data_ok) begin
               state_next = d_pend ? D_REQ : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Slot capture in IDLE, slot retirement and read-data load on data_ok in the matching WAIT state.
   always_ff @(posedge clk) begin
      if (rst) begin
         i_pend          <= 1'b0;
         i_wen           <= 4'b0;
         i_addr          <= '0;
         i_wdata         <= '0;
         d_pend          <= 1'b0;
         d_wen           <= 4'b0;
         d_addr          <= '0;
         d_wdata         <= '0;
         inst_sram_rdata <= '0;
         data_sram_rdata <= '0;
      end else begin
         if (state == IDLE) begin
            if (inst_sram_en) begin
               i_pend  <= 1'b1;
               i_wen   <= inst_sram_wen;
               i_addr  <= inst_sram_addr;
               i_wdata <= inst_sram_wdata;
            end
            if (data_sram_en) begin
               d_pend  <= 1'b1;
               d_wen   <= data_sram_wen;
               d_addr  <= data_sram_addr;
               d_wdata <= data_sram_wdata;
            end
         end
         if ((state == I_WAIT) && mem_data_ok) begin
            i_pend <= 1'b0;
            if (i_wen == 4'b0) begin
               inst_sram_rdata <= mem_rdata;
            end
         end
         if ((state == D_WAIT) && mem_data_ok) begin
            d_pend <= 1'b0;
            if (d_wen == 4'b0) begin
               data_sram_rdata <= mem_rdata;
            end
         end
      end
   end

   // Memory port driven purely from registered state and slots, so it cannot glitch while waiting for addr_ok.
   always_comb begin
      mem_req   = 1'b0;
      mem_wstrb = 4'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         D_REQ: begin
            mem_req   = 1'b1;
            mem_wstrb = d_wen;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
         end
         I_REQ: begin
            mem_req   = 1'b1;
            mem_wstrb = i_wen;
            mem_addr  = i_addr;
            mem_wdata = i_wdata;
         end
         default: ;
      endcase
      mem_wr   = (mem_wstrb != 4'b0);
      stallreq = (state != IDLE);
   end

endmodule
